// File: rtl/booth_product_accumulator_if.sv
// Valid/ready bundle between the Booth multiplier output and the block accumulator.
// The master side feeds products and consumes block sums; the accumulator is the slave.
interface booth_product_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
);
    logic [LEN_W-1:0]  cfg_len;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_sat;
    logic [LEN_W-1:0]  out_count;

    modport master (
        output cfg_len, in_valid, in_product, out_ready,
        input  in_ready, out_valid, out_sum, out_sat, out_count
    );

    modport slave (
        input  cfg_len, in_valid, in_product, out_ready,
        output in_ready, out_valid, out_sum, out_sat, out_count
    );
endinterface

// File: rtl/booth_product_accumulator.sv
// Saturating block accumulator for signed Booth products; emits one sum per cfg_len products.
//   state   | meaning
//   S_ACCUM | accepting products, adding into acc
//   S_DRAIN | block sum presented, waiting for out_ready
module booth_product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input logic                        clk,
    input logic                        rst_n,
    booth_product_accumulator_if.slave bus
);
    typedef enum logic {S_ACCUM = 1'b0, S_DRAIN = 1'b1} state_t;

    localparam logic signed [ACC_W:0] C_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] C_MIN = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic [LEN_W-1:0]      C_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0]        r_cnt;
    logic [LEN_W-1:0]        r_len_q;
    logic                    r_sat_q;
    logic [ACC_W-1:0]        r_out_sum;
    logic                    r_out_sat;
    logic [LEN_W-1:0]        r_out_count;

    logic                    w_ready;
    logic                    w_valid;
    logic                    w_in_rdy;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic                    w_first;
    logic                    w_last;
    logic                    w_ovf;
    logic                    w_sat_nxt;
    logic [LEN_W-1:0]        w_len_eff;
    logic [LEN_W-1:0]        w_len_cur;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W-1:0] w_acc_nxt;

    // The length is taken live from cfg_len only on a block's first product.
    assign w_first   = (r_cnt == '0);
    assign w_len_eff = (bus.cfg_len == '0) ? C_ONE : bus.cfg_len;
    assign w_len_cur = w_first ? w_len_eff : r_len_q;
    assign w_last    = ((r_cnt + C_ONE) == w_len_cur);

    assign w_sum = $signed({r_acc[ACC_W-1], r_acc})
                 + $signed({{(ACC_W+1-PROD_W){bus.in_product[PROD_W-1]}}, bus.in_product});

    always_comb begin
        w_ovf     = 1'b0;
        w_acc_nxt = w_sum[ACC_W-1:0];
        if (w_sum > C_MAX) begin
            w_ovf     = 1'b1;
            w_acc_nxt = C_MAX[ACC_W-1:0];
        end else if (w_sum < C_MIN) begin
            w_ovf     = 1'b1;
            w_acc_nxt = C_MIN[ACC_W-1:0];
        end
    end

    assign w_sat_nxt  = r_sat_q | w_ovf;
    assign w_in_rdy   = w_ready & rst_n;
    assign w_in_fire  = bus.in_valid & w_in_rdy;
    assign w_out_fire = w_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            S_ACCUM: begin
                w_ready = 1'b1;
                if (bus.in_valid && w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            default: w_state_nxt = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len_q     <= '0;
            r_sat_q     <= 1'b0;
            r_out_sum   <= '0;
            r_out_sat   <= 1'b0;
            r_out_count <= '0;
        end else if (w_in_fire) begin
            r_acc   <= w_acc_nxt;
            r_sat_q <= w_sat_nxt;
            r_cnt   <= r_cnt + C_ONE;
            if (w_first) begin
                r_len_q <= w_len_eff;
            end
            if (w_last) begin
                r_out_sum   <= w_acc_nxt;
                r_out_sat   <= w_sat_nxt;
                r_out_count <= w_len_cur;
            end
        end else if (w_out_fire) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat_q <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = w_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_sat   = r_out_sat;
    assign bus.out_count = r_out_count;
endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator at ACC_W=20 so saturation is reachable with 8-bit lengths.
// Fixed vectors, hand sequences for backpressure/reset, then random blocks against a plain-arithmetic model.
module tb_booth_product_accumulator;
    localparam int PROD_W = 16;
    localparam int ACC_W  = 20;
    localparam int LEN_W  = 8;
    localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W-1));

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    booth_product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    booth_product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int len;
        int n;
        int p0, p1, p2, p3;
        int esum;
        int esat;
        int ecnt;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int out_sum_i();
        return int'($signed(bus.out_sum));
    endfunction

    // Reference: running sum with clamping to the ACC_W signed range.
    function automatic void model(input int q[$], output int s, output int sat);
        longint a = 0;
        sat = 0;
        foreach (q[i]) begin
            a = a + longint'(q[i]);
            if (a > MAXV) begin
                a = MAXV;
                sat = 1;
            end else if (a < MINV) begin
                a = MINV;
                sat = 1;
            end
        end
        s = int'(a);
    endfunction

    task automatic push(input int p, input int idle);
        int t = 0;
        if (idle > 0) begin
            bus.in_valid = 1'b0;
            repeat (idle) begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid   = 1'b1;
        bus.in_product = p[PROD_W-1:0];
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            chk("push_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_check(input string name, input int esum, input int esat,
                             input int ecnt, input int delay);
        int t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({name, " out_valid"}, int'(bus.out_valid), 1);
        chk({name, " in_ready_low"}, int'(bus.in_ready), 0);
        repeat (delay) @(negedge clk);
        @(negedge clk);
        chk({name, " out_sum"}, out_sum_i(), esum);
        chk({name, " out_sat"}, int'(bus.out_sat), esat);
        chk({name, " out_count"}, int'(bus.out_count), ecnt);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({name, " in_ready_back"}, int'(bus.in_ready), 1);
        chk({name, " out_valid_drop"}, int'(bus.out_valid), 0);
    endtask

    task automatic do_block(input string name, input int len, input int q[$],
                            input int esum, input int esat, input int ecnt,
                            input int max_idle, input int delay);
        bus.cfg_len = len[LEN_W-1:0];
        foreach (q[i]) push(q[i], (max_idle > 0) ? $urandom_range(0, max_idle) : 0);
        chk({name, " latency"}, int'(bus.out_valid), 1);
        pop_check(name, esum, esat, ecnt, delay);
    endtask

    task automatic set_vec(input int i, input int len, input int n, input int a, input int b,
                           input int c, input int d, input int esum, input int esat,
                           input int ecnt);
        vt[i].len = len;  vt[i].n = n;
        vt[i].p0 = a;     vt[i].p1 = b;    vt[i].p2 = c;    vt[i].p3 = d;
        vt[i].esum = esum; vt[i].esat = esat; vt[i].ecnt = ecnt;
    endtask

    initial begin
        int q[$];
        int s;
        int sat;
        int len;
        int n;
        int mode;
        int p;

        set_vec(0, 3, 3,  39, -20, -42, 0,  -23, 0, 3);
        set_vec(1, 0, 1,  16,   0,   0, 0,   16, 0, 1);
        set_vec(2, 2, 2, 127,   0,   0, 0,  127, 0, 2);
        set_vec(3, 2, 2,   5,  -5,   0, 0,    0, 0, 2);
        set_vec(4, 4, 4,   1,   2,   3, 4,   10, 0, 4);
        set_vec(5, 1, 1, -32768, 0,  0, 0, -32768, 0, 1);

        rst_n         = 1'b0;
        bus.cfg_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_product = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst in_ready", int'(bus.in_ready), 0);
        chk("rst out_valid", int'(bus.out_valid), 0);
        chk("rst out_sum", out_sum_i(), 0);
        chk("rst out_sat", int'(bus.out_sat), 0);
        chk("rst out_count", int'(bus.out_count), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst in_ready", int'(bus.in_ready), 1);

        for (int i = 0; i < 6; i++) begin
            q = {};
            q.push_back(vt[i].p0);
            if (vt[i].n > 1) q.push_back(vt[i].p1);
            if (vt[i].n > 2) q.push_back(vt[i].p2);
            if (vt[i].n > 3) q.push_back(vt[i].p3);
            do_block($sformatf("vec%0d", i), vt[i].len, q, vt[i].esum, vt[i].esat,
                     vt[i].ecnt, 0, 0);
        end

        q = {};
        for (int i = 0; i < 17; i++) q.push_back(32767);
        do_block("sat_pos", 17, q, 524287, 1, 17, 0, 0);
        q = {5, -5};
        do_block("after_sat", 2, q, 0, 0, 2, 0, 0);

        q = {};
        for (int i = 0; i < 17; i++) q.push_back(-32768);
        do_block("sat_neg", 17, q, -524288, 1, 17, 0, 0);

        // Backpressure: a pending product must wait out the DRAIN state.
        bus.cfg_len = 8'd2;
        push(13, 0);
        push(3, 0);
        bus.in_valid   = 1'b1;
        bus.in_product = 16'd99;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp out_valid", int'(bus.out_valid), 1);
            chk("bp in_ready", int'(bus.in_ready), 0);
            chk("bp out_sum", out_sum_i(), 16);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp in_ready_back", int'(bus.in_ready), 1);
        push(99, 0);
        push(1, 0);
        pop_check("bp_next", 100, 0, 2, 0);

        // Asynchronous reset mid-block, then a block with cfg_len changed after its first product.
        bus.cfg_len = 8'd4;
        push(100, 0);
        push(200, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst in_ready", int'(bus.in_ready), 0);
        chk("mid_rst out_valid", int'(bus.out_valid), 0);
        chk("mid_rst out_sum", out_sum_i(), 0);
        chk("mid_rst out_sat", int'(bus.out_sat), 0);
        chk("mid_rst out_count", int'(bus.out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(1, 0);
        bus.cfg_len = 8'd9;
        push(2, 0);
        push(3, 0);
        chk("len_latch no_early", int'(bus.out_valid), 0);
        push(4, 0);
        chk("len_latch latency", int'(bus.out_valid), 1);
        pop_check("len_latch", 10, 0, 4, 1);

        for (int b = 0; b < 40; b++) begin
            len  = $urandom_range(0, 20);
            n    = (len == 0) ? 1 : len;
            mode = $urandom_range(0, 3);
            q = {};
            for (int i = 0; i < n; i++) begin
                if (mode == 0)      p = $urandom_range(30000, 32767);
                else if (mode == 1) p = -$urandom_range(30000, 32768);
                else                p = $urandom_range(0, 65535) - 32768;
                q.push_back(p);
            end
            model(q, s, sat);
            do_block($sformatf("rand%0d", b), len, q, s, sat, n, 2, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
